// File: rtl/uart_pkg.sv
// Shared constants and types for the UART FIFO bridge: default depth,
// the UART core's "no byte" marker, status word layout and TX FSM states.
package uart_pkg;

  localparam int DEPTH_LOG2_DEFAULT = 4;

  localparam logic [31:0] UART_NO_DATA = 32'hFFFF_FFFF;

  localparam int STA_TX_LEVEL_LSB = 0;
  localparam int STA_RX_LEVEL_LSB = 8;
  localparam int STA_TX_FULL      = 16;
  localparam int STA_TX_EMPTY     = 17;
  localparam int STA_RX_FULL      = 18;
  localparam int STA_RX_EMPTY     = 19;
  localparam int STA_TX_BUSY      = 20;

  typedef enum logic {
    TX_IDLE  = 1'b0,
    TX_WRITE = 1'b1
  } tx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Byte-wide synchronous FIFO with first-word-fall-through head output.
// A push is judged against the pre-pop fullness, so a full FIFO refuses it.
module sync_fifo #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  push,
  input  logic                  pop,
  input  logic [7:0]            din,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   level,
  output logic [7:0]            head
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic                  push_ok;
  logic                  pop_ok;

  // Level can only reach DEPTH, so its top bit alone marks a full FIFO.
  assign full    = level[DEPTH_LOG2];
  assign empty   = (level == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // Storage is never reset; stale entries are unreachable once pointers clear.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/uart_fifo_bridge.sv
// CPU-to-UART bridge: a TX FIFO drained by a two-state issue FSM and an RX
// FIFO filled straight from the UART core, plus a combinational status word.
module uart_fifo_bridge
  import uart_pkg::*;
#(
  parameter int DEPTH_LOG2 = DEPTH_LOG2_DEFAULT
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        bus_dat_we,
  input  logic [31:0] bus_dat_di,
  input  logic        bus_dat_re,
  output logic [31:0] bus_dat_do,
  output logic        bus_dat_wait,
  output logic [31:0] bus_sta_do,
  output logic        uart_we,
  output logic [31:0] uart_di,
  input  logic        uart_wait,
  output logic        uart_re,
  input  logic [31:0] uart_do
);

  tx_state_t             state;
  tx_state_t             state_next;
  logic                  tx_full, tx_empty, rx_full, rx_empty;
  logic [DEPTH_LOG2:0]   tx_level, rx_level;
  logic [7:0]            tx_head, rx_head;
  logic                  tx_push, tx_pop, rx_push, rx_pop;
  logic                  bus_di_unused;

  assign bus_di_unused = ^bus_dat_di[31:8];

  assign tx_push      = bus_dat_we && !tx_full;
  assign bus_dat_wait = bus_dat_we && tx_full;
  assign tx_pop       = uart_we && !uart_wait;

  // 0xFF arrives zero-extended, so only the all-ones word means "no byte".
  assign uart_re    = resetn && (uart_do != UART_NO_DATA) && !rx_full;
  assign rx_push    = uart_re;
  assign rx_pop     = bus_dat_re && !rx_empty;
  assign bus_dat_do = rx_empty ? UART_NO_DATA : {24'b0, rx_head};

  sync_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_tx_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (tx_push),
    .pop    (tx_pop),
    .din    (bus_dat_di[7:0]),
    .full   (tx_full),
    .empty  (tx_empty),
    .level  (tx_level),
    .head   (tx_head)
  );

  sync_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_rx_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (rx_push),
    .pop    (rx_pop),
    .din    (uart_do[7:0]),
    .full   (rx_full),
    .empty  (rx_empty),
    .level  (rx_level),
    .head   (rx_head)
  );

  always_ff @(posedge clk) begin
    if (!resetn) state <= TX_IDLE;
    else         state <= state_next;
  end

  // Returning to IDLE after every accept caps issue at one byte per two cycles.
  always_comb begin
    state_next = state;
    case (state)
      TX_IDLE:  if (!tx_empty) state_next = TX_WRITE;
      TX_WRITE: if (tx_pop)    state_next = TX_IDLE;
      default:  state_next = TX_IDLE;
    endcase
  end

  always_comb begin
    uart_we = (state == TX_WRITE);
    uart_di = {24'b0, tx_head};
  end

  always_comb begin
    bus_sta_do                                  = '0;
    bus_sta_do[STA_TX_LEVEL_LSB +: 8]           = 8'(tx_level);
    bus_sta_do[STA_RX_LEVEL_LSB +: 8]           = 8'(rx_level);
    bus_sta_do[STA_TX_FULL]                     = tx_full;
    bus_sta_do[STA_TX_EMPTY]                    = tx_empty;
    bus_sta_do[STA_RX_FULL]                     = rx_full;
    bus_sta_do[STA_RX_EMPTY]                    = rx_empty;
    bus_sta_do[STA_TX_BUSY]                     = (state == TX_WRITE);
  end

endmodule

// File: tb/tb_uart_fifo_bridge.sv
// Self-checking bench for uart_fifo_bridge: directed scenarios plus a random
// phase, all checked against a queue-based model of the bridge's behaviour.
module tb_uart_fifo_bridge;
  import uart_pkg::*;

  localparam int DL    = 4;
  localparam int DEPTH = 1 << DL;

  logic        clk;
  logic        resetn;
  logic        bus_dat_we;
  logic [31:0] bus_dat_di;
  logic        bus_dat_re;
  logic [31:0] bus_dat_do;
  logic        bus_dat_wait;
  logic [31:0] bus_sta_do;
  logic        uart_we;
  logic [31:0] uart_di;
  logic        uart_wait;
  logic        uart_re;
  logic [31:0] uart_do;

  uart_fifo_bridge #(.DEPTH_LOG2(DL)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .bus_dat_we   (bus_dat_we),
    .bus_dat_di   (bus_dat_di),
    .bus_dat_re   (bus_dat_re),
    .bus_dat_do   (bus_dat_do),
    .bus_dat_wait (bus_dat_wait),
    .bus_sta_do   (bus_sta_do),
    .uart_we      (uart_we),
    .uart_di      (uart_di),
    .uart_wait    (uart_wait),
    .uart_re      (uart_re),
    .uart_do      (uart_do)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: byte queues plus a flag for "a byte is on offer to the UART".
  logic [7:0] tx_q[$];
  logic [7:0] rx_q[$];
  bit         busy;
  logic [7:0] written[$];
  logic [7:0] dut_sent[$];
  int         dut_acc_cyc[$];
  int         vectors;
  int         miscompares;
  int         cyc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_sta();
    logic [31:0] s;
    s = '0;
    s[7:0]   = 8'(tx_q.size());
    s[15:8]  = 8'(rx_q.size());
    s[16]    = (tx_q.size() == DEPTH);
    s[17]    = (tx_q.size() == 0);
    s[18]    = (rx_q.size() == DEPTH);
    s[19]    = (rx_q.size() == 0);
    s[20]    = busy;
    return s;
  endfunction

  task automatic settle();
    #1;
  endtask

  // One clock: check all outputs against the model, then advance the model.
  task automatic cycle();
    bit tx_full_m, rx_full_m, rx_empty_m, exp_re, acc, next_busy;
    #1;
    tx_full_m  = (tx_q.size() == DEPTH);
    rx_full_m  = (rx_q.size() == DEPTH);
    rx_empty_m = (rx_q.size() == 0);
    exp_re     = (resetn === 1'b1) && (uart_do != UART_NO_DATA) && !rx_full_m;
    check("uart_we", 32'(uart_we), 32'(busy));
    if (busy) check("uart_di", uart_di, {24'b0, tx_q[0]});
    check("bus_dat_wait", 32'(bus_dat_wait), 32'(bus_dat_we && tx_full_m));
    check("uart_re", 32'(uart_re), 32'(exp_re));
    check("bus_dat_do", bus_dat_do, rx_empty_m ? UART_NO_DATA : {24'b0, rx_q[0]});
    check("bus_sta_do", bus_sta_do, model_sta());
    if (uart_we === 1'b1 && uart_wait === 1'b0) begin
      dut_sent.push_back(uart_di[7:0]);
      dut_acc_cyc.push_back(cyc);
    end
    acc = busy && !uart_wait;
    next_busy = busy ? !acc : (tx_q.size() != 0);
    @(posedge clk);
    cyc++;
    if (resetn !== 1'b1) begin
      tx_q.delete();
      rx_q.delete();
      busy = 1'b0;
    end else begin
      if (acc) void'(tx_q.pop_front());
      if (bus_dat_we && !tx_full_m) begin
        tx_q.push_back(bus_dat_di[7:0]);
        written.push_back(bus_dat_di[7:0]);
      end
      if (bus_dat_re && !rx_empty_m) void'(rx_q.pop_front());
      if (exp_re) rx_q.push_back(uart_do[7:0]);
      busy = next_busy;
    end
    #1;
  endtask

  task automatic drain_tx();
    uart_wait  = 1'b0;
    bus_dat_we = 1'b0;
    for (int k = 0; k < 100 && (tx_q.size() != 0 || busy); k++) cycle();
    check("tx_drain_bound", 32'(tx_q.size() == 0 && !busy), 32'd1);
  endtask

  initial begin
    int base;
    int n0;
    vectors     = 0;
    miscompares = 0;
    cyc         = 0;
    busy        = 1'b0;
    resetn      = 1'b0;
    bus_dat_we  = 1'b0;
    bus_dat_di  = '0;
    bus_dat_re  = 1'b0;
    uart_wait   = 1'b0;
    uart_do     = UART_NO_DATA;

    @(posedge clk);
    #1;
    uart_do = 32'h0000_0055;
    cycle();
    uart_do = UART_NO_DATA;
    cycle();
    resetn = 1'b1;
    settle();
    check("reset_sta", bus_sta_do, 32'h000A_0000);
    check("reset_do", bus_dat_do, 32'hFFFF_FFFF);
    check("reset_we", 32'(uart_we), 32'd0);

    // Two bytes with a free UART: issued two cycles apart, in order.
    base = dut_sent.size();
    bus_dat_we = 1'b1; bus_dat_di = 32'h0000_0041; cycle();
    bus_dat_di = 32'h0000_0042; cycle();
    bus_dat_we = 1'b0;
    for (int k = 0; k < 6; k++) cycle();
    check("two_byte_count", 32'(dut_sent.size() - base), 32'd2);
    if (dut_sent.size() >= base + 2) begin
      check("first_byte", 32'(dut_sent[base]), 32'h41);
      check("second_byte", 32'(dut_sent[base + 1]), 32'h42);
      check("issue_gap", 32'(dut_acc_cyc[base + 1] - dut_acc_cyc[base]), 32'd2);
    end
    settle();
    check("tx_empty_after", 32'(bus_sta_do[17]), 32'd1);

    // Stalled UART: 17th write waits until the UART drains one byte.
    uart_wait = 1'b1;
    for (int i = 0; i < 17; i++) begin
      bus_dat_we = 1'b1;
      bus_dat_di = {$urandom, 8'h00} | 32'(8'($urandom));
      if (i == 16) begin
        settle();
        check("full_wait", 32'(bus_dat_wait), 32'd1);
        check("full_level", 32'(bus_sta_do[7:0]), 32'd16);
        check("full_flag", 32'(bus_sta_do[16]), 32'd1);
      end
      cycle();
    end
    uart_wait = 1'b0;
    n0 = written.size();
    for (int k = 0; k < 10 && written.size() == n0; k++) cycle();
    check("stall_release_bound", 32'(written.size() - n0), 32'd1);
    drain_tx();

    // RX of byte 0xFF, then a read returns the FIFO to empty.
    uart_do = 32'h0000_00FF;
    settle();
    check("rx_ff_re", 32'(uart_re), 32'd1);
    cycle();
    uart_do = UART_NO_DATA;
    settle();
    check("rx_ff_do", bus_dat_do, 32'h0000_00FF);
    bus_dat_re = 1'b1;
    cycle();
    bus_dat_re = 1'b0;
    settle();
    check("rx_empty_do", bus_dat_do, 32'hFFFF_FFFF);

    // Full RX back-pressures the UART until one byte is read out.
    for (int i = 0; i < DEPTH; i++) begin
      uart_do = 32'(8'($urandom));
      cycle();
    end
    uart_do = 32'h0000_00A5;
    settle();
    check("rx_full_re", 32'(uart_re), 32'd0);
    check("rx_full_level", 32'(bus_sta_do[15:8]), 32'd16);
    cycle();
    bus_dat_re = 1'b1;
    cycle();
    bus_dat_re = 1'b0;
    settle();
    check("rx_freed_re", 32'(uart_re), 32'd1);
    cycle();
    uart_do = UART_NO_DATA;
    settle();
    check("rx_refill_level", 32'(bus_sta_do[15:8]), 32'd16);

    // Same-cycle RX push and bus pop at level 5.
    bus_dat_re = 1'b1;
    for (int k = 0; k < 20 && rx_q.size() > 5; k++) cycle();
    bus_dat_re = 1'b0;
    uart_do = 32'h0000_003C;
    bus_dat_re = 1'b1;
    cycle();
    uart_do = UART_NO_DATA;
    bus_dat_re = 1'b0;
    settle();
    check("push_pop_level", 32'(bus_sta_do[15:8]), 32'd5);
    cycle();

    // Random traffic on both directions.
    for (int i = 0; i < 400; i++) begin
      bus_dat_we = ($urandom_range(0, 1) == 1);
      bus_dat_di = $urandom;
      bus_dat_re = ($urandom_range(0, 4) < 2);
      uart_wait  = ($urandom_range(0, 1) == 1);
      case ($urandom_range(0, 7))
        0, 1, 2: uart_do = UART_NO_DATA;
        3:       uart_do = 32'h0000_00FF;
        default: uart_do = 32'(8'($urandom));
      endcase
      cycle();
    end
    bus_dat_re = 1'b0;
    uart_do    = UART_NO_DATA;
    drain_tx();
    check("sent_count", 32'(dut_sent.size()), 32'(written.size()));
    for (int i = 0; i < written.size() && i < dut_sent.size(); i++)
      check("sent_byte", 32'(dut_sent[i]), 32'(written[i]));

    // Reset while a byte is on offer and more are queued.
    uart_wait  = 1'b1;
    bus_dat_we = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus_dat_di = 32'(8'($urandom));
      cycle();
    end
    bus_dat_we = 1'b0;
    settle();
    check("pre_reset_we", 32'(uart_we), 32'd1);
    resetn  = 1'b0;
    uart_do = 32'h0000_0077;
    cycle();
    resetn  = 1'b1;
    uart_do = UART_NO_DATA;
    settle();
    check("mid_reset_we", 32'(uart_we), 32'd0);
    check("mid_reset_sta", bus_sta_do, 32'h000A_0000);
    cycle();
    cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
